// File: rtl/key_event_if.sv
// Event handshake between the key arbiter (producer) and its consumer.
// The producer presents the queue head; the consumer pops it with evt_ready.
interface key_event_if #(
    parameter int KEY_W = 2
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;

    modport master (output evt_valid, output evt_key, input evt_ready);
    modport slave  (input evt_valid, input evt_key, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Debounced pushbutton press detector: per-key sync + debounce, one pending
// flag per key, round-robin grant into a small event FIFO.
module key_event_arbiter #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    key_event_if.master       evt,
    output logic              overflow
);
    localparam int KW = $clog2(N_KEYS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_KEYS-1:0] sync1_q, sync2_q, deb_q, press_q;
    logic [CW-1:0]     cnt_q [N_KEYS];

    // Levels are active-low, so "released" is 1 everywhere after reset.
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q[gi] <= 1'b1;
                sync2_q[gi] <= 1'b1;
                deb_q[gi]   <= 1'b1;
                cnt_q[gi]   <= '0;
                press_q[gi] <= 1'b0;
            end else begin
                sync1_q[gi] <= key_n[gi];
                sync2_q[gi] <= sync1_q[gi];
                press_q[gi] <= 1'b0;
                if (sync2_q[gi] == deb_q[gi]) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_q[gi] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[gi]   <= sync2_q[gi];
                    cnt_q[gi]   <= '0;
                    press_q[gi] <= ~sync2_q[gi];
                end else begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    end

    logic [N_KEYS-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [KW-1:0]     rr_q, rr_d;
    logic [KW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q, count_d;

    logic              grant_valid;
    logic [KW-1:0]     grant_idx;
    logic [N_KEYS-1:0] grant_vec;
    logic              pop;

    function automatic int wrap_idx(input int v);
        return (v >= N_KEYS) ? v - N_KEYS : v;
    endfunction

    // Search starts at rr_q; fullness uses the registered count so a
    // same-cycle pop never frees a slot for this cycle's grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (count_q != (AW+1)'(FIFO_DEPTH)) begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (!grant_valid && pending_q[wrap_idx(int'(rr_q) + k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = KW'(wrap_idx(int'(rr_q) + k));
                end
            end
        end
    end

    assign grant_vec = grant_valid ? (N_KEYS'(1) << grant_idx) : '0;
    assign pop       = (count_q != '0) && evt.evt_ready;

    // A press landing on the cycle its key is granted is kept, not dropped.
    always_comb begin
        pending_d  = (pending_q & ~grant_vec) | press_q;
        overflow_d = overflow_q | (|(press_q & pending_q & ~grant_vec));
        rr_d       = rr_q;
        if (grant_valid)
            rr_d = (int'(grant_idx) == N_KEYS - 1) ? '0 : grant_idx + KW'(1);
        count_d = count_q;
        if (grant_valid && !pop)
            count_d = count_q + 1'b1;
        else if (!grant_valid && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            if (grant_valid) begin
                mem_q[wr_q] <= grant_idx;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_key   = mem_q[rd_q];
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized and directed bench for key_event_arbiter against a
// sample-history reference model of debounce, pending flags and event queue.
module tb_key_event_arbiter;
    localparam int N  = 4;
    localparam int D  = 16;
    localparam int FD = 4;
    localparam int KW = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] key_n = '1;
    logic         overflow;

    key_event_if #(.KEY_W(KW)) evt_if ();

    key_event_arbiter #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .evt      (evt_if),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: a key's level flips once its last D synchronized
    // samples all disagree with it; synchronized = raw sampled two edges ago.
    logic [N-1:0] m_hist [0:D+1];
    logic [N-1:0] m_deb, m_press, m_pend;
    int           m_rr;
    int           m_q[$];
    bit           m_ovf;

    function automatic void model_reset();
        for (int j = 0; j <= D + 1; j++) m_hist[j] = '1;
        m_deb = '1; m_press = '0; m_pend = '0; m_rr = 0; m_ovf = 0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit           do_pop;
        int           g;
        logic [N-1:0] np, npress;
        bit           all_diff;
        do_pop = (m_q.size() > 0) && evt_if.evt_ready;
        g = -1;
        if (m_q.size() < FD)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        np = m_pend;
        if (g >= 0) np[g] = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_press[i]) begin
                if (np[i]) m_ovf = 1;
                np[i] = 1'b1;
            end
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_rr = (g + 1) % N;
        end
        for (int j = D + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = key_n;
        npress = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = 1;
            for (int j = 2; j <= D + 1; j++)
                if (m_hist[j][i] == m_deb[i]) all_diff = 0;
            if (all_diff) begin
                m_deb[i] = ~m_deb[i];
                if (m_deb[i] == 1'b0) npress[i] = 1'b1;
            end
        end
        m_press = npress;
        m_pend  = np;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("evt_valid", int'(evt_if.evt_valid), int'(m_q.size() > 0));
            check("overflow", int'(overflow), int'(m_ovf));
            if (m_q.size() > 0) check("evt_key", int'(evt_if.evt_key), m_q[0]);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edge1();
        edge1();
        reset = 1'b0;
    endtask

    // Counts edges from now until evt_valid first rises; also tallies valid cycles.
    task automatic watch(input int n, output int rise, output int key, output int vcnt);
        rise = 0; key = -1; vcnt = 0;
        for (int e = 1; e <= n; e++) begin
            edge1();
            if (evt_if.evt_valid) begin
                vcnt++;
                if (rise == 0) begin rise = e; key = int'(evt_if.evt_key); end
            end
        end
    endtask

    int rise, key, vcnt, k0, k1, k2, ev;
    int dur [N];

    initial begin
        evt_if.evt_ready = 1'b1;
        edge1();
        do_reset();
        check("reset_valid", int'(evt_if.evt_valid), 0);
        check("reset_key", int'(evt_if.evt_key), 0);
        check("reset_overflow", int'(overflow), 0);

        // Single press on key 2: one-cycle pulse at edge D+4, nothing on release.
        key_n = 4'b1011;
        watch(30, rise, key, vcnt);
        check("press_latency", rise, D + 4);
        check("press_key", key, 2);
        check("press_pulse_len", vcnt, 1);
        key_n = 4'b1111;
        watch(30, rise, key, vcnt);
        check("release_no_event", vcnt, 0);

        // Short glitch on key 0 is filtered.
        key_n = 4'b1110;
        repeat (10) edge1();
        key_n = 4'b1111;
        watch(40, rise, key, vcnt);
        check("glitch_no_event", vcnt, 0);

        // Simultaneous presses on keys 0,1,3 queue in round-robin order.
        do_reset();
        evt_if.evt_ready = 1'b0;
        key_n = 4'b0100;
        repeat (30) edge1();
        key_n = 4'b1111;
        repeat (25) edge1();
        evt_if.evt_ready = 1'b1;
        k0 = int'(evt_if.evt_key); check("drain_valid0", int'(evt_if.evt_valid), 1);
        edge1();
        k1 = int'(evt_if.evt_key); check("drain_valid1", int'(evt_if.evt_valid), 1);
        edge1();
        k2 = int'(evt_if.evt_key); check("drain_valid2", int'(evt_if.evt_valid), 1);
        edge1();
        check("drain_key0", k0, 0);
        check("drain_key1", k1, 1);
        check("drain_key3", k2, 3);
        check("drain_empty", int'(evt_if.evt_valid), 0);

        // Six presses of key 1 with a stalled consumer: 4 queued, 1 pending, 1 dropped.
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            key_n = 4'b1101;
            repeat (22) edge1();
            key_n = 4'b1111;
            repeat (22) edge1();
        end
        check("overflow_set", int'(overflow), 1);
        evt_if.evt_ready = 1'b1;
        ev = 0;
        for (int e = 0; e < 12; e++) begin
            if (evt_if.evt_valid && evt_if.evt_key == 2'd1) ev++;
            edge1();
        end
        check("overflow_drain_count", ev, 5);
        check("overflow_sticky", int'(overflow), 1);

        // Asynchronous reset mid-cycle with events queued; key 2 held through it.
        evt_if.evt_ready = 1'b0;
        key_n = 4'b0100;
        repeat (25) edge1();
        check("pre_reset_valid", int'(evt_if.evt_valid), 1);
        key_n = 4'b1011;
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_valid", int'(evt_if.evt_valid), 0);
        check("async_reset_overflow", int'(overflow), 0);
        edge1();
        edge1();
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;
        watch(45, rise, key, vcnt);
        check("post_reset_latency", rise, D + 4);
        check("post_reset_key", key, 2);
        check("post_reset_count", vcnt, 1);
        key_n = 4'b1111;

        // Random key activity with random consumer back-pressure and resets.
        do_reset();
        for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    key_n[i] = ~key_n[i];
                    dur[i] = $urandom_range(1, 40);
                end
            end
            evt_if.evt_ready = ($urandom_range(0, 99) < 35);
            if (c % 1500 == 1499) reset = 1'b1;
            if (c % 1500 == 2) reset = 1'b0;
            edge1();
        end
        reset = 1'b0;
        edge1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameter N_KEYS, default 4, number of pushbutton inputs (2..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a level change (>=2).
REQ-003 Parameter FIFO_DEPTH, default 4, event queue depth (power of two, >=2).
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately on assertion, released synchronously to clk.
REQ-006 key_n  input  N_KEYS  raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 evt_valid  output  1  event queue head is valid.
REQ-008 evt_ready  input  1  consumer accepts head this cycle.
REQ-009 evt_key  output  clog2(N_KEYS)  index of key for head event.
REQ-010 overflow  output  1  sticky: at least one press event was dropped since reset.

Function
REQ-011 Each key_n bit SHALL pass through a dedicated two-flop synchronizer; only the second-stage output feeds further logic.
REQ-012 Per key, a debouncer SHALL hold a debounced level and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 Debounce: cycle where synced != debounced -> counter+1; when counter == DEBOUNCE_CYCLES-1 and still different -> debounced <= synced, counter <= 0.
REQ-014 Debounce: any cycle where synced == debounced SHALL clear counter to 0 (glitch shorter than DEBOUNCE_CYCLES produces no change).
REQ-015 Press event: debounced transition released->pressed; release transitions SHALL generate no event.
REQ-016 Press event for key i SHALL set pending[i] on the following edge.
REQ-017 Press event while pending[i] already 1: event dropped, pending[i] stays 1, overflow <= 1 (sticky until reset).
REQ-018 Arbiter: each cycle FIFO is not full and any pending bit is set, grant exactly one key, round-robin starting at rr_ptr, write its index to FIFO, clear its pending bit, rr_ptr <= grant+1 mod N_KEYS.
REQ-019 Simultaneous grant-clear and new press on same key: pending[i] SHALL remain 1 (new event kept, no overflow).
REQ-020 FIFO full: no grant; pending bits hold; no events lost, no overflow from fullness alone.
REQ-021 evt_valid = FIFO not empty; evt_key = head entry; pop on evt_valid && evt_ready.
REQ-022 evt_key SHALL stay stable while evt_valid && !evt_ready.
REQ-023 Push and pop in same cycle (FIFO neither empty nor full): occupancy unchanged, order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-024 Push when full is blocked even if pop occurs same cycle (full-check uses registered count).
REQ-025 Latency, idle block: evt_valid SHALL rise after rising edge number DEBOUNCE_CYCLES+4, counting the first edge that samples key_n low as edge 1 (20 for default).
REQ-026 Events from one key SHALL emerge in press order; events from different keys follow grant order.

Reset
REQ-027 Reset SHALL set: synchronizers and debounced levels = released, counters 0, pending 0, rr_ptr 0, FIFO empty, evt_valid 0, evt_key 0, overflow 0.
REQ-028 Reset mid-operation discards queued and pending events; a key held low through reset release SHALL yield one event DEBOUNCE_CYCLES+4 edges after release.

Verification
REQ-029 Key 2 held low 30 cycles, evt_ready=1 -> evt_valid pulses 1 cycle at edge 20 with evt_key=2; no event on release.
REQ-030 Key 0 glitch low for 10 cycles then high -> no event, counter returns 0, evt_valid stays 0.
REQ-031 Keys 0,1,3 pressed same cycle, rr_ptr=0, evt_ready=0 -> FIFO holds 0,1,3 in order; then evt_ready=1 -> drained 0,1,3 on consecutive cycles.
REQ-032 evt_ready=0, key 1 pressed/released 6 times (FIFO_DEPTH=4) -> 4 queued, pending[1]=1, 6th press sets overflow=1; draining yields 5 events of key 1.
REQ-033 Reset asserted asynchronously mid-clock with 3 queued events -> evt_valid and overflow drop to 0 before next edge; no stale event after release.
